// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Handshake bundle between the decode/execute/writeback stages
//                and the pipeline controller. The slave modport is the
//                controller's view; the master modport is the pipeline's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    // Decode-stage instruction fields
    logic        id_valid_i;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic [4:0]  reg_waddr_i;
    // Execute-stage requests
    logic        ex_hold_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    // Writeback port
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    // Pipeline register controls
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        pc_jump_o;
    logic [31:0] jump_addr_o;
    logic        issue_o;
    logic [31:0] stall_cnt_o;

    modport slave (
        input  id_valid_i, reg1_raddr_i, reg2_raddr_i, reg_waddr_i,
        input  ex_hold_i, jump_i, jump_addr_i, wb_we_i, wb_waddr_i,
        output hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o,
        output pc_jump_o, jump_addr_o, issue_o, stall_cnt_o
    );

    modport master (
        output id_valid_i, reg1_raddr_i, reg2_raddr_i, reg_waddr_i,
        output ex_hold_i, jump_i, jump_addr_i, wb_we_i, wb_waddr_i,
        input  hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o,
        input  pc_jump_o, jump_addr_o, issue_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline controller for the nanosoc core. Sequences the PC,
//                IF/ID and ID/EX registers around decode: a 32-entry
//                scoreboard of pending writebacks stalls decode on RAW/WAW
//                hazards, EX hold requests freeze the front end, and taken
//                jumps flush IF/ID for FLUSH_CYCLES cycles.
//                Optional feature macro: PIPE_CTRL_FORWARD_EN - lets a
//                same-cycle writeback satisfy a hazard (regfile write-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pipe_ctrl_if.slave bus
);

    // Counter only ever holds FLUSH_CYCLES-1 down to 0.
    localparam int c_CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_FLUSH_LOAD = c_CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [31:0]        r_sb;
    logic [31:0]        w_sb_nxt;
    logic [31:0]        r_stall_cnt;

    logic w_rs1_busy, w_rs2_busy, w_rd_busy;
    logic w_rs1_fwd,  w_rs2_fwd,  w_rd_fwd;
    logic w_hazard;

    logic w_hold_pc;
    logic w_hold_if_id;
    logic w_flush_if_id;
    logic w_flush_id_ex;
    logic w_pc_jump;
    logic w_issue;

    // Register x0 never becomes busy, so a zero address never hazards.
    assign w_rs1_busy = (bus.reg1_raddr_i != 5'd0) && r_sb[bus.reg1_raddr_i];
    assign w_rs2_busy = (bus.reg2_raddr_i != 5'd0) && r_sb[bus.reg2_raddr_i];
    assign w_rd_busy  = (bus.reg_waddr_i  != 5'd0) && r_sb[bus.reg_waddr_i];

`ifdef PIPE_CTRL_FORWARD_EN
    // A writeback landing this cycle is visible through the regfile, so the
    // matching scoreboard entry no longer blocks decode.
    assign w_rs1_fwd = bus.wb_we_i && (bus.wb_waddr_i == bus.reg1_raddr_i);
    assign w_rs2_fwd = bus.wb_we_i && (bus.wb_waddr_i == bus.reg2_raddr_i);
    assign w_rd_fwd  = bus.wb_we_i && (bus.wb_waddr_i == bus.reg_waddr_i);
`else
    // Without write-through the scoreboard alone decides.
    assign w_rs1_fwd = 1'b0;
    assign w_rs2_fwd = 1'b0;
    assign w_rd_fwd  = 1'b0;
`endif

    assign w_hazard = (w_rs1_busy && !w_rs1_fwd)
                   || (w_rs2_busy && !w_rs2_fwd)
                   || (w_rd_busy  && !w_rd_fwd);

    // Next-state and output decode; priority is reset > jump > flush > hold > hazard.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hold_pc     = 1'b0;
        w_hold_if_id  = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_pc_jump     = 1'b0;
        w_issue       = 1'b0;

        if (rst) begin
            // Keep bubbles flowing while reset is held.
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            w_state_nxt   = ST_RUN;
            w_cnt_nxt     = '0;
        end else if (bus.jump_i) begin
            w_pc_jump     = 1'b1;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            w_cnt_nxt     = c_FLUSH_LOAD;
            w_state_nxt   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (r_state == ST_FLUSH) begin
            // Wrong-path fetches keep getting squashed; EX holds a bubble so
            // an EX hold request has nothing to protect here.
            w_flush_if_id = 1'b1;
            if (r_cnt <= c_CNT_W'(1)) begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end else begin
                w_cnt_nxt   = r_cnt - c_CNT_W'(1);
            end
        end else if (bus.ex_hold_i) begin
            // EX keeps its own register; ID/EX is neither loaded nor flushed.
            w_hold_pc     = 1'b1;
            w_hold_if_id  = 1'b1;
            w_state_nxt   = ST_HOLD;
        end else if (bus.id_valid_i && w_hazard) begin
            // Freeze the front end and feed EX a bubble until the source retires.
            w_hold_pc     = 1'b1;
            w_hold_if_id  = 1'b1;
            w_flush_id_ex = 1'b1;
            w_state_nxt   = ST_RUN;
        end else begin
            w_issue       = bus.id_valid_i;
            w_state_nxt   = ST_RUN;
        end
    end

    // Per-register scoreboard update; an issue setting a bit beats a
    // writeback clearing the same bit in the same cycle.
    assign w_sb_nxt[0] = 1'b0;
    for (genvar gi = 1; gi < 32; gi++) begin : g_sb
        logic w_set;
        logic w_clr;
        assign w_set = w_issue && (bus.reg_waddr_i == 5'(gi));
        assign w_clr = bus.wb_we_i && (bus.wb_waddr_i == 5'(gi));
        assign w_sb_nxt[gi] = w_set || (r_sb[gi] && !w_clr);
    end

    // FSM state and flush counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Scoreboard register; reset forgets any outstanding writebacks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_nxt;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hold_pc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.hold_pc_o     = w_hold_pc;
    assign bus.hold_if_id_o  = w_hold_if_id;
    assign bus.flush_if_id_o = w_flush_if_id;
    assign bus.flush_id_ex_o = w_flush_id_ex;
    assign bus.pc_jump_o     = w_pc_jump;
    assign bus.jump_addr_o   = bus.jump_addr_i;
    assign bus.issue_o       = w_issue;
    assign bus.stall_cnt_o   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed, table-driven bench for pipe_ctrl: one row per
//                clock cycle with inputs and expected control outputs, plus a
//                hand-written jump/flush length sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int FLUSH_CYCLES = 2;

    // Packed expected outputs: {hold_pc, hold_if_id, flush_if_id, flush_id_ex, pc_jump, issue}
    localparam logic [5:0] O_RESET = 6'b001100;
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_ISSUE = 6'b000001;
    localparam logic [5:0] O_STALL = 6'b110100;
    localparam logic [5:0] O_HOLD  = 6'b110000;
    localparam logic [5:0] O_JUMP  = 6'b001110;
    localparam logic [5:0] O_FLUSH = 6'b001000;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        hold;
        logic        jmp;
        logic        we;
        logic [4:0]  wa;
        logic [5:0]  exp;
        logic [31:0] scnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipe_ctrl_if u_if ();

    pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic hold, input logic jmp, input logic we,
                                input logic [4:0] wa, input logic [5:0] exp,
                                input logic [31:0] scnt);
        vec_t t;
        t.rst = r;   t.v = v;       t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.hold = hold; t.jmp = jmp; t.we = we;   t.wa = wa;
        t.exp = exp; t.scnt = scnt;
        return t;
    endfunction

    function automatic logic [5:0] outs();
        return {u_if.hold_pc_o, u_if.hold_if_id_o, u_if.flush_if_id_o,
                u_if.flush_id_ex_o, u_if.pc_jump_o, u_if.issue_o};
    endfunction

    task automatic drive(input vec_t t, input logic [31:0] ja);
        rst               = t.rst;
        u_if.id_valid_i   = t.v;
        u_if.reg1_raddr_i = t.rs1;
        u_if.reg2_raddr_i = t.rs2;
        u_if.reg_waddr_i  = t.rd;
        u_if.ex_hold_i    = t.hold;
        u_if.jump_i       = t.jmp;
        u_if.jump_addr_i  = ja;
        u_if.wb_we_i      = t.we;
        u_if.wb_waddr_i   = t.wa;
    endtask

    vec_t vecs[21];

    initial begin
        int s5;
        int s;
        int n;
        bit done;
        logic [31:0] ja;

        s5 = FWD ? 2 : 3;
        s  = FWD ? 3 : 5;

        //               rst v  rs1   rs2   rd     hld jmp we  wa
        vecs[0]  = mk(1, 0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 5'd0, O_RESET, 0);
        vecs[1]  = mk(0, 1, 5'd0, 5'd0, 5'd5,  0, 0, 0, 5'd0, O_ISSUE, 0);
        vecs[2]  = mk(0, 1, 5'd5, 5'd0, 5'd6,  0, 0, 0, 5'd0, O_STALL, 0);
        vecs[3]  = mk(0, 1, 5'd5, 5'd0, 5'd6,  0, 0, 0, 5'd0, O_STALL, 1);
        vecs[4]  = mk(0, 1, 5'd5, 5'd0, 5'd6,  0, 0, 1, 5'd5, FWD ? O_ISSUE : O_STALL, 2);
        vecs[5]  = mk(0, !FWD, 5'd5, 5'd0, 5'd6, 0, 0, 0, 5'd0, FWD ? O_IDLE : O_ISSUE, s5);
        vecs[6]  = mk(0, 1, 5'd0, 5'd0, 5'd0,  0, 0, 1, 5'd6, O_ISSUE, s5);
        vecs[7]  = mk(0, 1, 5'd0, 5'd0, 5'd0,  0, 0, 0, 5'd0, O_ISSUE, s5);
        vecs[8]  = mk(0, 1, 5'd0, 5'd6, 5'd7,  0, 0, 1, 5'd7, O_ISSUE, s5);
        vecs[9]  = mk(0, 1, 5'd7, 5'd0, 5'd0,  0, 0, 0, 5'd0, O_STALL, s5);
        vecs[10] = mk(0, 1, 5'd7, 5'd0, 5'd0,  0, 0, 1, 5'd7, FWD ? O_ISSUE : O_STALL, s5 + 1);
        vecs[11] = mk(0, 0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 5'd0, O_IDLE, s);
        vecs[12] = mk(0, 1, 5'd0, 5'd0, 5'd8,  1, 0, 0, 5'd0, O_HOLD, s);
        vecs[13] = mk(0, 1, 5'd0, 5'd0, 5'd8,  1, 1, 0, 5'd0, O_JUMP, s + 1);
        vecs[14] = mk(0, 1, 5'd0, 5'd0, 5'd8,  1, 0, 0, 5'd0, O_FLUSH, s + 1);
        vecs[15] = mk(0, 1, 5'd0, 5'd0, 5'd8,  0, 0, 0, 5'd0, O_ISSUE, s + 1);
        vecs[16] = mk(0, 1, 5'd0, 5'd0, 5'd9,  0, 1, 0, 5'd0, O_JUMP, s + 1);
        vecs[17] = mk(1, 1, 5'd0, 5'd0, 5'd10, 0, 0, 0, 5'd0, O_RESET, s + 1);
        vecs[18] = mk(0, 1, 5'd8, 5'd0, 5'd0,  0, 0, 0, 5'd0, O_ISSUE, 0);
        vecs[19] = mk(0, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 5'd0, O_HOLD, 0);
        vecs[20] = mk(0, 0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 5'd0, O_IDLE, 1);

        drive(vecs[0], 32'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            ja = 32'h1000_0000 + 32'(i * 4);
            drive(vecs[i], ja);
            #3;
            total++;
            if (outs() !== vecs[i].exp) begin
                bad++;
                $display("FAIL row%0d outs: got %b want %b", i, outs(), vecs[i].exp);
            end
            total++;
            if (u_if.stall_cnt_o !== vecs[i].scnt) begin
                bad++;
                $display("FAIL row%0d stall_cnt: got %0d want %0d", i, u_if.stall_cnt_o, vecs[i].scnt);
            end
            total++;
            if (u_if.jump_addr_o !== ja) begin
                bad++;
                $display("FAIL row%0d jump_addr: got %h want %h", i, u_if.jump_addr_o, ja);
            end
        end

        // Jump from RUN, then measure how long IF/ID stays flushed.
        @(posedge clk);
        #1;
        drive(mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 5'd0, O_IDLE, 0), 32'hDEAD_BEE0);
        #3;
        total++;
        if (outs() !== O_JUMP) begin
            bad++;
            $display("FAIL seq_jump outs: got %b want %b", outs(), O_JUMP);
        end
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1;
            drive(mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, O_IDLE, 0), 32'h0);
            #3;
            if (u_if.flush_if_id_o === 1'b1 && u_if.issue_o === 1'b0)
                n++;
            else
                done = 1'b1;
        end
        total++;
        if (!done || n != FLUSH_CYCLES - 1) begin
            bad++;
            $display("FAIL seq_flush_len: got %0d cycles (ended=%0d) want %0d", n, done, FLUSH_CYCLES - 1);
        end
        total++;
        if (outs() !== O_ISSUE) begin
            bad++;
            $display("FAIL seq_resume outs: got %b want %b", outs(), O_ISSUE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
